// File: rtl/spi_reg_master_pkg.sv
// Shared types and frame helpers for the SPI register-file initiator.
package spi_reg_master_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SHIFT,
      HOLD,
      GAP
   } state_t;

   localparam int FRAME_W  = 16;
   localparam int RW_BIT   = 15;
   localparam int DATA_LSB = 0;

   // Frame layout: R/W flag, zero-padded address in the upper byte, data byte
   // (zero for reads) in the lower byte.
   function automatic logic [FRAME_W-1:0] build_frame(
      input logic       write,
      input logic [6:0] addr,
      input logic [7:0] wdata
   );
      logic [FRAME_W-1:0] frame;
      frame                  = '0;
      frame[RW_BIT]          = write;
      frame[14:8]            = addr;
      frame[DATA_LSB +: 8]   = write ? wdata : 8'h00;
      return frame;
   endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK generator: half-period divider, 0..32 edge counter, edge strobes.
// Strobes are asserted in the clk cycle whose rising edge moves spi_clk.
module spi_sclk_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic i_ena,
   input  logic i_cpol,
   input  logic i_run,
   output logic o_lead_edge,
   output logic o_trail_edge,
   output logic o_shift_end,
   output logic o_hold_end,
   output logic o_sclk
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [DIV_W-1:0] r_div;
   logic [5:0]       r_edge;
   logic             r_sclk;
   logic             w_tick;
   logic             w_more;

   assign w_tick       = i_run && i_ena && (r_div == DIV_W'(CLK_DIV - 1));
   assign w_more       = (r_edge < 6'd32);
   assign o_lead_edge  = w_tick && w_more && !r_edge[0];
   assign o_trail_edge = w_tick && w_more && r_edge[0];
   assign o_shift_end  = w_tick && (r_edge == 6'd31);
   assign o_hold_end   = w_tick && !w_more;
   assign o_sclk       = r_sclk;

   // Divider and edge counter; idle level tracks cpol while not running.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         r_div  <= '0;
         r_edge <= '0;
         r_sclk <= 1'b0;
      end else if (i_ena) begin
         if (!i_run) begin
            r_div  <= '0;
            r_edge <= '0;
            r_sclk <= i_cpol;
         end else begin
            r_div <= w_tick ? '0 : r_div + 1'b1;
            if (w_tick && w_more) begin
               r_edge <= r_edge + 6'd1;
               r_sclk <= ~r_sclk;
            end
         end
      end
   end

endmodule

// File: rtl/spi_reg_master.sv
// SPI initiator issuing single 16-bit register read/write frames.
module spi_reg_master
   import spi_reg_master_pkg::*;
#(
   parameter int CLK_DIV = 4,
   parameter int ADDR_W  = 3,
   parameter int CS_GAP  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ena,
   input  logic [1:0]        mode,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [7:0]        cmd_wdata,
   output logic              rsp_valid,
   output logic [7:0]        rsp_rdata,
   output logic              busy,
   output logic              spi_cs_n,
   output logic              spi_clk,
   output logic              spi_mosi,
   input  logic              spi_miso
);

   localparam int GAP_W = $clog2(CS_GAP + 1);

   state_t             r_state;
   state_t             w_next;
   logic [1:0]         r_mode;
   logic [FRAME_W-1:0] r_shift;
   logic               r_mosi;
   logic [7:0]         r_rx;
   logic [7:0]         r_rdata;
   logic               r_rsp_valid;
   logic [GAP_W-1:0]   r_gap_cnt;
   logic               r_ready_en;

   logic               w_accept;
   logic               w_run;
   logic               w_lead;
   logic               w_trail;
   logic               w_shift_end;
   logic               w_hold_end;
   logic               w_sclk;
   logic               w_shift_edge;
   logic               w_sample_edge;
   logic [FRAME_W-1:0] w_frame;

   spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
      .clk          (clk),
      .rst          (rst),
      .i_ena        (ena),
      .i_cpol       (r_mode[1]),
      .i_run        (w_run),
      .o_lead_edge  (w_lead),
      .o_trail_edge (w_trail),
      .o_shift_end  (w_shift_end),
      .o_hold_end   (w_hold_end),
      .o_sclk       (w_sclk)
   );

   assign w_run         = (r_state == SHIFT) || (r_state == HOLD);
   assign w_shift_edge  = r_mode[0] ? w_lead  : w_trail;
   assign w_sample_edge = r_mode[0] ? w_trail : w_lead;
   assign w_frame       = build_frame(cmd_write, 7'(cmd_addr), cmd_wdata);
   assign spi_clk       = w_run ? w_sclk : r_mode[1];
   assign rsp_valid     = r_rsp_valid;
   assign rsp_rdata     = r_rdata;

   // State register; ena low freezes the sequence in place.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else if (ena) begin
         r_state <= w_next;
      end
   end

   // Next-state decode and per-state output levels.
   always_comb begin
      // NOTE: defaults first so no path leaves a signal unassigned (no latches).
      w_next    = r_state;
      w_accept  = 1'b0;
      cmd_ready = 1'b0;
      busy      = 1'b1;
      spi_cs_n  = 1'b1;
      spi_mosi  = 1'b0;
      case (r_state)
         IDLE: begin
            busy      = 1'b0;
            cmd_ready = ena && r_ready_en;
            w_accept  = cmd_valid && ena && r_ready_en;
            if (w_accept) w_next = SETUP;
         end
         SETUP: w_next = SHIFT;
         SHIFT: begin
            spi_cs_n = 1'b0;
            spi_mosi = r_mosi;
            if (w_shift_end) w_next = HOLD;
         end
         HOLD: begin
            spi_cs_n = 1'b0;
            if (w_hold_end) w_next = GAP;
         end
         GAP: begin
            if (r_gap_cnt == GAP_W'(CS_GAP - 1)) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // Frame shift-out, MISO capture, response pulse and cs_n gap timing.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mode      <= 2'b00;
         r_shift     <= '0;
         r_mosi      <= 1'b0;
         r_rx        <= 8'h00;
         r_rdata     <= 8'h00;
         r_rsp_valid <= 1'b0;
         r_gap_cnt   <= '0;
         r_ready_en  <= 1'b0;
      end else if (ena) begin
         r_ready_en  <= 1'b1;
         r_rsp_valid <= w_hold_end;
         if (r_state == IDLE) r_mode <= mode;
         if (w_accept) begin
            // CPHA=0 presents bit15 before the first edge; CPHA=1 drives it on edge 1.
            if (!mode[0]) begin
               r_mosi  <= w_frame[FRAME_W-1];
               r_shift <= {w_frame[FRAME_W-2:0], 1'b0};
            end else begin
               r_mosi  <= 1'b0;
               r_shift <= w_frame;
            end
         end else if (w_shift_edge) begin
            r_mosi  <= r_shift[FRAME_W-1];
            r_shift <= {r_shift[FRAME_W-2:0], 1'b0};
         end
         // Eight-deep shift keeps only the last eight samples: the data byte.
         if (w_sample_edge) r_rx <= {r_rx[6:0], spi_miso};
         if (w_hold_end) r_rdata <= r_rx;
         r_gap_cnt <= (r_state == GAP) ? r_gap_cnt + 1'b1 : '0;
      end
   end

endmodule

// File: tb/tb_spi_reg_master.sv
// Directed bench for spi_reg_master with a behavioural SPI responder.
module tb_spi_reg_master;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ena = 1'b1;
   logic [1:0] mode = 2'b00;
   logic       cmd_valid = 1'b0;
   logic       cmd_write = 1'b0;
   logic [2:0] cmd_addr = 3'd0;
   logic [7:0] cmd_wdata = 8'h00;
   logic       spi_miso = 1'b0;
   logic       cmd_ready, rsp_valid, busy, spi_cs_n, spi_clk, spi_mosi;
   logic [7:0] rsp_rdata;

   int n_tests = 0;
   int n_fail  = 0;

   spi_reg_master #(.CLK_DIV(4), .ADDR_W(3), .CS_GAP(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .ena       (ena),
      .mode      (mode),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_write (cmd_write),
      .cmd_addr  (cmd_addr),
      .cmd_wdata (cmd_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .busy      (busy),
      .spi_cs_n  (spi_cs_n),
      .spi_clk   (spi_clk),
      .spi_mosi  (spi_mosi),
      .spi_miso  (spi_miso)
   );

   always #5 clk = ~clk;

   // Responder model: samples MOSI, drives {0x00, m_resp} on MISO.
   logic        mosi_prev = 1'b0;
   logic        m_prev_cs = 1'b1;
   logic        m_prev_clk = 1'b0;
   logic        m_cpha = 1'b0;
   logic [7:0]  m_resp = 8'h00;
   logic [15:0] m_word = 16'h0000;
   logic [15:0] m_mosi = 16'h0000;
   int          m_edges = 0;
   int          m_idx = 0;

   always @(negedge clk) mosi_prev = spi_mosi;

   always @(spi_clk or spi_cs_n) begin
      if (spi_cs_n !== m_prev_cs) begin
         m_prev_cs = spi_cs_n;
         if (spi_cs_n === 1'b0) begin
            m_edges = 0;
            m_mosi  = 16'h0000;
            m_word  = {8'h00, m_resp};
            m_idx   = 15;
            if (!m_cpha) begin
               spi_miso = m_word[15];
               m_idx    = 14;
            end
         end
      end
      if (spi_clk !== m_prev_clk) begin
         m_prev_clk = spi_clk;
         if (spi_cs_n === 1'b0) begin
            m_edges++;
            if ((m_edges % 2 == 1) ^ m_cpha) begin
               m_mosi = {m_mosi[14:0], mosi_prev};
            end else if (m_idx >= 0) begin
               spi_miso = m_word[m_idx];
               m_idx--;
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Results of the most recent run_frame call.
   int         t_fall, t_rise, t_rsp, t_ready, n_rsp;
   logic [7:0] r_data;
   logic       frozen_ok, busy_ok;

   // Issues one command; cycle numbers count clk edges after the accept edge.
   task automatic run_frame(input logic [1:0] md, input logic wr, input logic [2:0] ad,
                            input logic [7:0] wd, input logic [7:0] resp, input int drop_at);
      int         wait_n;
      logic [4:0] snap;
      mode = md; m_cpha = md[0]; m_resp = resp;
      cmd_write = wr; cmd_addr = ad; cmd_wdata = wd;
      tick;
      check("idle_sclk", spi_clk, md[1]);
      wait_n = 0;
      while (!cmd_ready && wait_n < 50) begin
         tick;
         wait_n++;
      end
      check("ready_before", cmd_ready, 1);
      cmd_valid = 1'b1;
      tick;
      cmd_valid = 1'b0;
      t_fall = -1; t_rise = -1; t_rsp = -1; t_ready = -1; n_rsp = 0;
      r_data = 8'hxx; frozen_ok = 1'b1; busy_ok = 1'b1; snap = '0;
      for (int n = 1; n <= 400; n++) begin
         if (drop_at > 0 && n == drop_at) begin
            snap = {spi_cs_n, spi_clk, spi_mosi, busy, rsp_valid};
            ena  = 1'b0;
         end
         if (drop_at > 0 && n == drop_at + 10) begin
            frozen_ok = (snap === {spi_cs_n, spi_clk, spi_mosi, busy, rsp_valid});
            ena = 1'b1;
         end
         tick;
         if (t_fall < 0 && !spi_cs_n) t_fall = n;
         if (t_fall >= 0 && t_rise < 0 && spi_cs_n) t_rise = n;
         if (rsp_valid) begin
            n_rsp++;
            t_rsp  = n;
            r_data = rsp_rdata;
         end
         if (cmd_ready) begin
            t_ready = n;
            break;
         end
         if (!busy) busy_ok = 1'b0;
      end
      ena = 1'b1;
   endtask

   typedef struct {
      logic [1:0]  md;
      logic        wr;
      logic [2:0]  ad;
      logic [7:0]  wd;
      logic [7:0]  resp;
      int          drop;
      logic [15:0] exp_mosi;
      logic [7:0]  exp_rdata;
      int          exp_rsp;
      int          exp_ready;
   } vec_t;

   vec_t vecs[6];
   int   acc, ready_low, gap_hi, b2b_rsp, abort_rsp;
   logic seen_low, will_acc;

   initial begin
      // md, wr, ad, wd, resp, drop, mosi, rdata, rsp cycle, ready cycle
      vecs[0] = '{2'd0, 1'b1, 3'd2, 8'h35, 8'hA7, 0,  16'h8235, 8'hA7, 133, 137};
      vecs[1] = '{2'd0, 1'b0, 3'd4, 8'hFF, 8'hC4, 0,  16'h0400, 8'hC4, 133, 137};
      vecs[2] = '{2'd3, 1'b0, 3'd5, 8'h00, 8'h10, 0,  16'h0500, 8'h10, 133, 137};
      vecs[3] = '{2'd1, 1'b1, 3'd7, 8'hE1, 8'h6B, 0,  16'h87E1, 8'h6B, 133, 137};
      vecs[4] = '{2'd2, 1'b0, 3'd3, 8'h12, 8'h81, 0,  16'h0300, 8'h81, 133, 137};
      vecs[5] = '{2'd0, 1'b1, 3'd1, 8'h5A, 8'h3E, 60, 16'h815A, 8'h3E, 143, 147};

      // Reset state.
      repeat (3) tick;
      check("rst_cs_n",  spi_cs_n,  1);
      check("rst_sclk",  spi_clk,   0);
      check("rst_mosi",  spi_mosi,  0);
      check("rst_rsp",   rsp_valid, 0);
      check("rst_rdata", rsp_rdata, 8'h00);
      check("rst_busy",  busy,      0);
      check("rst_ready", cmd_ready, 0);
      rst = 1'b0;
      tick;
      check("ready_after_rst", cmd_ready, 1);

      // Single frames across all four modes, plus an ena stall mid-SHIFT.
      for (int i = 0; i < 6; i++) begin
         if (i > 0) check("rdata_hold", rsp_rdata, vecs[i-1].exp_rdata);
         run_frame(vecs[i].md, vecs[i].wr, vecs[i].ad, vecs[i].wd, vecs[i].resp, vecs[i].drop);
         check("cs_fall",   t_fall,  1);
         check("cs_rise",   t_rise,  vecs[i].exp_rsp);
         check("rsp_cycle", t_rsp,   vecs[i].exp_rsp);
         check("ready_cyc", t_ready, vecs[i].exp_ready);
         check("rsp_count", n_rsp,   1);
         check("rdata",     r_data,  vecs[i].exp_rdata);
         check("mosi_word", m_mosi,  vecs[i].exp_mosi);
         check("sclk_edges", m_edges, 32);
         check("busy_held", busy_ok, 1);
         if (vecs[i].drop > 0) check("ena_freeze", frozen_ok, 1);
      end

      // Back-to-back reads with cmd_valid held high until the second accept.
      mode = 2'd0; m_cpha = 1'b0; m_resp = 8'h3C;
      cmd_write = 1'b0; cmd_addr = 3'd1; cmd_wdata = 8'h00;
      tick;
      acc = 0; ready_low = 0; gap_hi = 0; b2b_rsp = 0; seen_low = 1'b0;
      cmd_valid = 1'b1;
      for (int n = 0; n < 320; n++) begin
         will_acc = cmd_valid && cmd_ready;
         tick;
         if (will_acc) begin
            acc++;
            if (acc == 2) cmd_valid = 1'b0;
         end
         if (rsp_valid) b2b_rsp++;
         if (acc == 1) begin
            if (!cmd_ready) ready_low++;
            if (!spi_cs_n) seen_low = 1'b1;
            if (seen_low && spi_cs_n && !cmd_ready) gap_hi++;
         end
      end
      cmd_valid = 1'b0;
      check("b2b_accepts",   acc,       2);
      check("b2b_ready_low", ready_low, 137);
      check("b2b_gap",       gap_hi,    4);
      check("b2b_rsp",       b2b_rsp,   2);
      check("b2b_rdata",     rsp_rdata, 8'h3C);
      check("b2b_mosi",      m_mosi,    16'h0100);

      // Reset at cycle 60 of a mode-3 write frame.
      mode = 2'd3; m_cpha = 1'b1; m_resp = 8'hEE;
      cmd_write = 1'b1; cmd_addr = 3'd6; cmd_wdata = 8'h99;
      tick;
      cmd_valid = 1'b1;
      tick;
      cmd_valid = 1'b0;
      for (int n = 1; n < 60; n++) tick;
      rst = 1'b1;
      tick;
      check("abort_cs_n",  spi_cs_n,  1);
      check("abort_sclk",  spi_clk,   0);
      check("abort_rsp",   rsp_valid, 0);
      check("abort_busy",  busy,      0);
      check("abort_rdata", rsp_rdata, 8'h00);
      rst = 1'b0;
      abort_rsp = 0;
      for (int n = 0; n < 150; n++) begin
         tick;
         if (rsp_valid) abort_rsp++;
      end
      check("abort_no_rsp", abort_rsp, 0);

      // Normal read after the aborted frame.
      run_frame(2'd0, 1'b0, 3'd6, 8'h00, 8'h55, 0);
      check("post_rst_rsp",   t_rsp,  133);
      check("post_rst_rdata", r_data, 8'h55);
      check("post_rst_mosi",  m_mosi, 16'h0600);
      check("post_rst_count", n_rsp,  1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
      $fatal(1, "watchdog");
   end

endmodule
